// File: rtl/spi_slv.sv
// SPI mode-0 slave: samples SCLK/MOSI/SS_N in the clk domain, shifts MOSI in MSB-first,
// returns a word latched at frame start on MISO, and reports each frame with a valid pulse.
`timescale 1ns/1ps
module spi_slv #(
  parameter int unsigned SPI_MAXLEN = 32,
  parameter int unsigned CNT_W      = $clog2(SPI_MAXLEN + 1)
) (
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic [CNT_W-1:0]      rx_nbits,
  output logic                  rx_valid,
  output logic                  overrun,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  SS_N
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(SPI_MAXLEN);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state, state_d;

  logic [2:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;

  logic [SPI_MAXLEN-1:0] tx_shift, tx_shift_d;
  logic [SPI_MAXLEN-1:0] rx_shift, rx_shift_d;
  logic [SPI_MAXLEN-1:0] rx_data_d;
  logic [CNT_W-1:0]      cnt, cnt_d, rx_nbits_d;
  logic                  ovf, ovf_d, pend, pend_d;
  logic                  overrun_d, rx_valid_d, busy_d;

  // Two-flop synchronisers plus an edge-detect flop; idle bus levels at reset
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      sclk_sync <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 3'b000;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      ss_sync   <= {ss_sync[1:0], SS_N};
      mosi_sync <= {mosi_sync[1:0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign mosi_s    = mosi_sync[2];

  // MISO is the top bit of the transmit shifter, which is cleared whenever the FSM is idle
  assign MISO = tx_shift[SPI_MAXLEN-1];

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      pend     <= 1'b0;
      rx_data  <= '0;
      rx_nbits <= '0;
      overrun  <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      tx_shift <= tx_shift_d;
      rx_shift <= rx_shift_d;
      cnt      <= cnt_d;
      ovf      <= ovf_d;
      pend     <= pend_d;
      rx_data  <= rx_data_d;
      rx_nbits <= rx_nbits_d;
      overrun  <= overrun_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
    end
  end

  // Next-state and datapath; a select fall seen in DONE is held in pend for the next IDLE cycle
  always_comb begin
    state_d    = state;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    cnt_d      = cnt;
    ovf_d      = ovf;
    pend_d     = pend;
    rx_data_d  = rx_data;
    rx_nbits_d = rx_nbits;
    overrun_d  = overrun;
    rx_valid_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall || pend) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          pend_d     = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d    = DONE;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift[SPI_MAXLEN-2:0], mosi_s};
          if (cnt == MAX_CNT) ovf_d = 1'b1;
          else                cnt_d = cnt + CNT_W'(1);
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift[SPI_MAXLEN-2:0], 1'b0};
        end
      end
      DONE: begin
        state_d    = IDLE;
        rx_data_d  = rx_shift;
        rx_nbits_d = cnt;
        overrun_d  = ovf;
        rx_valid_d = 1'b1;
        if (ss_fall) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
